// File: rtl/mips_cpu_halt_monitor.sv
// rtl/mips_cpu_halt_monitor.sv - run/halt/timeout monitor for the mips_cpu_harvard bench
// Tracks IDLE -> RUN -> SETTLE -> DONE and latches sticky verdict flags plus the final register_v0.
module mips_cpu_halt_monitor #(
    parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS   = 32'h00000000,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          SETTLE_CYCLES  = 2,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    input  logic                 active,
    input  logic [31:0]          instr_address,
    input  logic [31:0]          register_v0,
    input  logic                 check_enable,
    input  logic [31:0]          expected_v0,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [31:0]          final_v0,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_END = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_END  = CNT_WIDTH'(SETTLE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   settle_q, settle_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic                   timeout_q, timeout_d;
    logic [31:0]            final_q, final_d;

    logic                   halt_seen;
    logic                   v0_match;
    logic [CNT_WIDTH-1:0]   cycle_inc;

    assign halt_seen = (instr_address == HALT_ADDRESS) || !active;
    assign v0_match  = (register_v0 == expected_v0);
    assign cycle_inc = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            settle_q  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            final_q   <= '0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            final_q   <= final_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        settle_d  = settle_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        final_d   = final_q;
        case (state_q)
            S_IDLE: begin
                if (active && (instr_address == RESET_VECTOR)) begin
                    state_d = S_RUN;
                    cycle_d = CNT_ONE;
                end
            end
            S_RUN: begin
                // Halt takes priority over a timeout landing on the same edge.
                if (halt_seen) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                    cycle_d  = cycle_inc;
                end else if (cycle_q == TIMEOUT_END) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    pass_d    = 1'b0;
                    final_d   = register_v0;
                end else begin
                    cycle_d = cycle_inc;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_END) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    final_d = register_v0;
                    pass_d  = check_enable ? v0_match : 1'b1;
                    fail_d  = check_enable ? !v0_match : 1'b0;
                end else begin
                    settle_d = settle_q + CNT_ONE;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign final_v0    = final_q;
    assign cycle_count = cycle_q;

endmodule
